// File: rtl/uart_byte_receiver.sv
// 8N1 LSB-first UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start validation, level-style drdy, framing-error reporting and break hold-off.
module uart_byte_receiver #(
    parameter int unsigned BAUD_DIV = 2083
) (
    input  logic       clk_12MHz,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       drdy,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        drdy_q, drdy_d;
    logic        ferr_q, ferr_d;
    logic        tick;

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            drdy_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitidx_q  <= bitidx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            drdy_q    <= drdy_d;
            ferr_q    <= ferr_d;
        end
    end

    assign tick = (cnt_q == 16'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        drdy_d   = drdy_q;
        ferr_d   = ferr_q;
        // The counter only runs while a frame is being timed; IDLE and BREAK hold it.
        if (state_q != S_IDLE && state_q != S_BREAK)
            cnt_d = tick ? FULL_RELOAD : cnt_q - 16'd1;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        drdy_d   = 1'b0;
                        bitidx_d = '0;
                        state_d  = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d[bitidx_q] = rx_s_q;
                    bitidx_d          = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        data_d  = shreg_q;
                        drdy_d  = 1'b1;
                        ferr_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = data_q;
    assign drdy      = drdy_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
